imem_boot_loader: RTL and testbench

- Boot sequencer that owns the core's reset and the instruction-memory write port during program load.
- Holds the core in reset while it accepts a stream of 32-bit instruction words on a valid/ready interface.
- Writes each word to consecutive word-aligned byte addresses, waits a fixed settle period, then releases the core.
- Sits between the SoC/testbench load source and cpu_top. Replaces backdoor loading of the instruction memory with a synthesizable path.

---
 rtl/imem_boot_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Boot sequencer that holds the core in reset while a stream of instruction
// words is written into instruction memory over a valid/ready interface.
// After the last write it waits HOLD_CYCLES cycles, then releases the core.
// A new start request from RUN reloads the memory and reboots the core.
module imem_boot_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int BASE_ADDR   = 0,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-2:0] i_word_count,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_wdata,
    output logic                  o_core_reset_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    // Word counters are one bit narrower than the byte address.
    localparam int CNT_W = ADDR_WIDTH - 1;
    // Range check is done two bits wider than the address so the end
    // address of the largest possible request cannot wrap.
    localparam int CHK_W = ADDR_WIDTH + 2;

    localparam logic [CNT_W-1:0]      CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = ADDR_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = DATA_WIDTH'(0);
    localparam logic [CHK_W-1:0]      CHK_BASE   = CHK_W'(BASE_ADDR);
    localparam logic [CHK_W-1:0]      MEM_BYTES  = {2'b01, {ADDR_WIDTH{1'b0}}};
    localparam logic [7:0]            HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]            HOLD_ZERO  = 8'd0;
    localparam logic [7:0]            HOLD_ONE   = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    // True when a load of cnt words starting at BASE_ADDR would run past
    // the end of instruction memory. Ending exactly at the top is legal.
    function automatic logic count_too_big(input logic [CNT_W-1:0] cnt);
        logic [CHK_W-1:0] end_addr;
        end_addr = CHK_BASE + {1'b0, cnt, 2'b00};
        return (end_addr > MEM_BYTES);
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    start_ok_s;
    logic                    start_err_s;
    logic                    transfer_s;

    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        word_cnt_r;
    logic [7:0]              hold_cnt_r;
    logic [ADDR_WIDTH-1:0]   next_addr_r;

    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    core_reset_n_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    error_r;

    // Next-state decode: start validation, word transfers and hold timeout.
    always_comb begin
        state_nxt_s = state_r;
        start_ok_s  = 1'b0;
        start_err_s = 1'b0;
        transfer_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (i_start) begin
                    if (count_too_big(i_word_count)) begin
                        // Rejected: stay put, core keeps its current reset state.
                        start_err_s = 1'b1;
                        state_nxt_s = state_r;
                    end else if (i_word_count == CNT_ZERO) begin
                        // Nothing to load: boot whatever the memory holds.
                        start_ok_s  = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        start_ok_s  = 1'b1;
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOAD: begin
                // o_ready is high for the whole of LOAD, so valid alone
                // marks a transfer here.
                transfer_s = i_valid;
                if (i_valid && ((word_cnt_r + CNT_ONE) == count_r)) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus the status outputs that follow the next state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            core_reset_n_r <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            busy_r         <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_HOLD);
            done_r         <= (state_nxt_s == ST_RUN);
            core_reset_n_r <= (state_nxt_s == ST_RUN);
            error_r        <= start_err_s;
        end
    end

    // Word and hold counters; the hold counter restarts whenever HOLD is left.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_r    <= CNT_ZERO;
            word_cnt_r <= CNT_ZERO;
            hold_cnt_r <= HOLD_ZERO;
        end else begin
            if (start_ok_s) begin
                count_r    <= i_word_count;
                word_cnt_r <= CNT_ZERO;
            end else if (transfer_s) begin
                word_cnt_r <= word_cnt_r + CNT_ONE;
            end else begin
                word_cnt_r <= word_cnt_r;
            end
            if (state_r == ST_HOLD) begin
                hold_cnt_r <= hold_cnt_r + HOLD_ONE;
            end else begin
                hold_cnt_r <= HOLD_ZERO;
            end
        end
    end

    // Memory write port: one registered write per accepted word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            we_r        <= 1'b0;
            addr_r      <= ADDR_ZERO;
            wdata_r     <= DATA_ZERO;
            next_addr_r <= ADDR_ZERO;
        end else begin
            we_r <= transfer_s;
            if (start_ok_s) begin
                next_addr_r <= ADDR_BASE;
            end else if (transfer_s) begin
                next_addr_r <= next_addr_r + ADDR_STEP;
            end else begin
                next_addr_r <= next_addr_r;
            end
            if (transfer_s) begin
                addr_r  <= next_addr_r;
                wdata_r <= i_data;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
        end
    end

    assign o_ready        = (state_r == ST_LOAD);
    assign o_imem_we      = we_r;
    assign o_imem_addr    = addr_r;
    assign o_imem_wdata   = wdata_r;
    assign o_core_reset_n = core_reset_n_r;
    assign o_busy         = busy_r;
    assign o_done         = done_r;
    assign o_error        = error_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader. Two instances: default parameters
// (dut_a) and BASE_ADDR=1000 (dut_b) for the end-of-memory boundary.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_imem_boot_loader;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_a;
    logic          start_b;
    logic [AW-2:0] word_count;
    logic [DW-1:0] data;
    logic          valid;

    logic          a_ready, a_we, a_core_rst_n, a_busy, a_done, a_error;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_ready, b_we, b_core_rst_n, b_busy, b_done, b_error;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    imem_boot_loader dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_word_count(word_count),
        .i_data(data), .i_valid(valid), .o_ready(a_ready), .o_imem_we(a_we),
        .o_imem_addr(a_addr), .o_imem_wdata(a_wdata), .o_core_reset_n(a_core_rst_n),
        .o_busy(a_busy), .o_done(a_done), .o_error(a_error)
    );

    imem_boot_loader #(.BASE_ADDR(1000)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_word_count(word_count),
        .i_data(data), .i_valid(valid), .o_ready(b_ready), .o_imem_we(b_we),
        .o_imem_addr(b_addr), .o_imem_wdata(b_wdata), .o_core_reset_n(b_core_rst_n),
        .o_busy(b_busy), .o_done(b_done), .o_error(b_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Back-to-back load of n words into dut_a; expects dut_a already in LOAD.
    task automatic load_words(input int n, input logic [31:0] d0, input int a0);
        valid = 1'b1;
        data  = d0;
        for (int k = 0; k < n; k++) begin
            step();
            check("load_we",    64'(a_we),    64'd1);
            check("load_addr",  64'(a_addr),  64'(a0 + 4 * k));
            check("load_wdata", 64'(a_wdata), 64'(d0 + 32'(k)));
            if (k < n - 1) data = d0 + 32'(k + 1);
            else           valid = 1'b0;
        end
        check("last_ready", 64'(a_ready),      64'd0);
        check("last_busy",  64'(a_busy),       64'd1);
        check("last_crst",  64'(a_core_rst_n), 64'd0);
    endtask

    // First HOLD cycle already observed; core is released on the third edge after.
    task automatic wait_release();
        step();
        check("hold1_crst",  64'(a_core_rst_n), 64'd0);
        check("hold1_we",    64'(a_we),         64'd0);
        check("hold1_ready", 64'(a_ready),      64'd0);
        step();
        check("hold2_crst",  64'(a_core_rst_n), 64'd0);
        check("hold2_done",  64'(a_done),       64'd0);
        step();
        check("run_crst", 64'(a_core_rst_n), 64'd1);
        check("run_done", 64'(a_done),       64'd1);
        check("run_busy", 64'(a_busy),       64'd0);
        check("run_we",   64'(a_we),         64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; word_count = '0;
        data = '0; valid = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_we",    64'(a_we),         64'd0);
        check("rst_addr",  64'(a_addr),       64'd0);
        check("rst_wdata", 64'(a_wdata),      64'd0);
        check("rst_crst",  64'(a_core_rst_n), 64'd0);
        check("rst_busy",  64'(a_busy),       64'd0);
        check("rst_done",  64'(a_done),       64'd0);
        check("rst_error", 64'(a_error),      64'd0);
        check("rst_ready", 64'(a_ready),      64'd0);
        rst = 1'b0;
        step();

        // Basic load of 8 words
        start_a = 1'b1; word_count = 9'd8;
        step();
        start_a = 1'b0;
        check("basic_ready", 64'(a_ready),      64'd1);
        check("basic_busy",  64'(a_busy),       64'd1);
        check("basic_crst",  64'(a_core_rst_n), 64'd0);
        check("basic_we0",   64'(a_we),         64'd0);
        load_words(8, 32'h40A18233, 0);
        wait_release();

        // Reload from RUN; a second start during LOAD is ignored
        start_a = 1'b1; word_count = 9'd2;
        step();
        check("reload_crst",  64'(a_core_rst_n), 64'd0);
        check("reload_done",  64'(a_done),       64'd0);
        check("reload_ready", 64'(a_ready),      64'd1);
        word_count = 9'd300;
        valid = 1'b1; data = 32'hCAFE0000;
        step();
        check("reload_we0",   64'(a_we),    64'd1);
        check("reload_addr0", 64'(a_addr),  64'd0);
        check("reload_data0", 64'(a_wdata), 64'hCAFE0000);
        check("reload_err0",  64'(a_error), 64'd0);
        start_a = 1'b0; data = 32'hCAFE0001;
        step();
        valid = 1'b0;
        check("reload_addr1", 64'(a_addr),  64'd4);
        check("reload_data1", 64'(a_wdata), 64'hCAFE0001);
        check("reload_err1",  64'(a_error), 64'd0);
        check("reload_rdy1",  64'(a_ready), 64'd0);
        wait_release();

        // Throttled source: valid 1,0,0,1,... for 4 words
        start_a = 1'b1; word_count = 9'd4;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid = (i % 3 == 0);
            data  = 32'h11110000 + 32'(i / 3);
            step();
            check("thr_we", 64'(a_we), 64'(i % 3 == 0));
            if (i % 3 == 0) begin
                check("thr_addr", 64'(a_addr),  64'(4 * (i / 3)));
                check("thr_data", 64'(a_wdata), 64'(32'h11110000 + 32'(i / 3)));
            end
        end
        valid = 1'b0;
        check("thr_ready_end", 64'(a_ready), 64'd0);
        wait_release();

        // Overflow reject from RUN: core keeps running
        start_a = 1'b1; word_count = 9'd257;
        step();
        start_a = 1'b0;
        check("rej_run_err",  64'(a_error),      64'd1);
        check("rej_run_crst", 64'(a_core_rst_n), 64'd1);
        check("rej_run_done", 64'(a_done),       64'd1);
        check("rej_run_busy", 64'(a_busy),       64'd0);
        step();
        check("rej_run_pulse", 64'(a_error), 64'd0);

        // Zero-count boot with valid held high (must be ignored)
        start_a = 1'b1; word_count = 9'd0; valid = 1'b1; data = 32'hDEADBEEF;
        step();
        start_a = 1'b0;
        check("zero_ready", 64'(a_ready),      64'd0);
        check("zero_we",    64'(a_we),         64'd0);
        check("zero_crst",  64'(a_core_rst_n), 64'd0);
        check("zero_busy",  64'(a_busy),       64'd1);
        wait_release();
        valid = 1'b0;

        // Mid-load reset after 3 of 8 words
        start_a = 1'b1; word_count = 9'd8;
        step();
        start_a = 1'b0;
        valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data = 32'h50000000 + 32'(k);
            step();
        end
        valid = 1'b0;
        check("mid_addr_pre", 64'(a_addr), 64'd8);
        #2 rst = 1'b1;
        #1;
        check("mid_we",    64'(a_we),         64'd0);
        check("mid_addr",  64'(a_addr),       64'd0);
        check("mid_wdata", 64'(a_wdata),      64'd0);
        check("mid_crst",  64'(a_core_rst_n), 64'd0);
        check("mid_busy",  64'(a_busy),       64'd0);
        check("mid_ready", 64'(a_ready),      64'd0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Overflow reject in IDLE
        start_a = 1'b1; word_count = 9'd257;
        step();
        start_a = 1'b0;
        check("rej_idle_err",   64'(a_error), 64'd1);
        check("rej_idle_busy",  64'(a_busy),  64'd0);
        check("rej_idle_ready", 64'(a_ready), 64'd0);
        check("rej_idle_we",    64'(a_we),    64'd0);
        step();
        check("rej_idle_pulse", 64'(a_error), 64'd0);

        // Restart after reset, start and valid together: only the start is taken
        start_a = 1'b1; word_count = 9'd8; valid = 1'b1; data = 32'h77777777;
        step();
        start_a = 1'b0; valid = 1'b0;
        check("restart_we",    64'(a_we),    64'd0);
        check("restart_ready", 64'(a_ready), 64'd1);
        load_words(8, 32'h60000000, 0);
        wait_release();

        // BASE_ADDR=1000: 7 words overflow, 6 words end exactly at 1024
        start_b = 1'b1; word_count = 9'd7;
        step();
        check("b_rej_err",  64'(b_error), 64'd1);
        check("b_rej_busy", 64'(b_busy),  64'd0);
        word_count = 9'd6;
        step();
        start_b = 1'b0;
        check("b_acc_err",   64'(b_error), 64'd0);
        check("b_acc_ready", 64'(b_ready), 64'd1);
        valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data = 32'h70000000 + 32'(k);
            step();
            check("b_we",    64'(b_we),    64'd1);
            check("b_addr",  64'(b_addr),  64'(1000 + 4 * k));
            check("b_wdata", 64'(b_wdata), 64'(32'h70000000 + 32'(k)));
            check("a_run_no_we", 64'(a_we), 64'd0);
        end
        valid = 1'b0;
        check("b_ready_end", 64'(b_ready), 64'd0);
        repeat (2) step();
        check("b_hold_crst", 64'(b_core_rst_n), 64'd0);
        step();
        check("b_run_crst", 64'(b_core_rst_n), 64'd1);
        check("b_run_done", 64'(b_done),       64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
